// File: rtl/ser_word_tx.sv
// ----------------------------------------------------------------------------
// ser_word_tx
//   Serial transmitter for parallel register/counter words. One WIDTH-bit word
//   is accepted per load/ready handshake and is shifted out on a single line
//   as a frame: start bit (0), data LSB first, optional even-parity bit, and
//   stop bit (1). Each line bit is held for CLKS_PER_BIT clock cycles.
//
//   Optional feature macro: SER_WORD_TX_PARITY_EN
//     Defined   -> PARITY state between DATA and STOP, carrying the XOR of
//                  the latched data bits.
//     Undefined -> no parity state or parity logic.
//
// Parameters:
//   WIDTH        data word width (1..16)
//   CLKS_PER_BIT clock cycles per line bit (1..255)
//
// Ports:
//   Clk    in   system clock, all state on posedge
//   Clear  in   synchronous active-high reset
//   din    in   word to transmit, sampled when load && ready
//   load   in   request to send din
//   ready  out  high only in IDLE
//   sout   out  registered serial line, idles high
//   busy   out  frame in progress (~ready)
//   done   out  one-cycle pulse on the first IDLE cycle after the stop bit
// ----------------------------------------------------------------------------
module ser_word_tx #(
   parameter int unsigned WIDTH        = 5,
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic             Clk,
   input  logic             Clear,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SER_WORD_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CW-1:0]    r_cyc;
   logic [CW-1:0]    w_cyc_nxt;
   logic [BW-1:0]    r_bit;
   logic [BW-1:0]    w_bit_nxt;
   logic             r_sout;
   logic             w_sout_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_cyc_last;
   logic             w_accept;

`ifdef SER_WORD_TX_PARITY_EN
   // Parity is captured at acceptance because the shift register is
   // consumed while the data bits go out.
   logic             r_par;

   always_ff @(posedge Clk) begin
      if (Clear) begin
         r_par <= 1'b0;
      end else if (w_accept) begin
         r_par <= ^din;
      end
   end
`endif

   assign w_cyc_last = (r_cyc == CYC_LAST);
   assign w_accept   = (r_state == S_IDLE) && load;

   // Next-state, datapath and next line value. The line is registered, so its
   // next value is decoded from the next state and next shift contents; this
   // puts the start bit on the line in the cycle right after acceptance.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cyc_nxt   = r_cyc;
      w_bit_nxt   = r_bit;
      w_done_nxt  = 1'b0;
      w_sout_nxt  = 1'b1;

      unique case (r_state)
         S_IDLE: begin
            if (load) begin
               w_state_nxt = S_START;
               w_shift_nxt = din;
               w_cyc_nxt   = '0;
               w_bit_nxt   = '0;
            end
         end
         S_START: begin
            if (w_cyc_last) begin
               w_state_nxt = S_DATA;
               w_cyc_nxt   = '0;
            end else begin
               w_cyc_nxt = r_cyc + 1'b1;
            end
         end
         S_DATA: begin
            if (w_cyc_last) begin
               w_cyc_nxt   = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_bit == BIT_LAST) begin
                  w_bit_nxt = '0;
`ifdef SER_WORD_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end else begin
               w_cyc_nxt = r_cyc + 1'b1;
            end
         end
`ifdef SER_WORD_TX_PARITY_EN
         S_PARITY: begin
            if (w_cyc_last) begin
               w_state_nxt = S_STOP;
               w_cyc_nxt   = '0;
            end else begin
               w_cyc_nxt = r_cyc + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (w_cyc_last) begin
               w_state_nxt = S_IDLE;
               w_cyc_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cyc_nxt = r_cyc + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cyc_nxt   = '0;
            w_bit_nxt   = '0;
         end
      endcase

      unique case (w_state_nxt)
         S_IDLE:   w_sout_nxt = 1'b1;
         S_START:  w_sout_nxt = 1'b0;
         S_DATA:   w_sout_nxt = w_shift_nxt[0];
`ifdef SER_WORD_TX_PARITY_EN
         S_PARITY: w_sout_nxt = r_par;
`endif
         S_STOP:   w_sout_nxt = 1'b1;
         default:  w_sout_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clear) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cyc   <= '0;
         r_bit   <= '0;
         r_sout  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cyc   <= w_cyc_nxt;
         r_bit   <= w_bit_nxt;
         r_sout  <= w_sout_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ready = (r_state == S_IDLE);
   assign busy  = ~ready;
   assign sout  = r_sout;
   assign done  = r_done;

endmodule
